// File: rtl/sad_search_sequencer.sv
// rtl/sad_search_sequencer.sv - raster-order window issue and running-minimum SAD collector.
// Optional feature: define SAD_EARLY_EXIT_EN to stop issuing on the first zero SAD.
module sad_search_sequencer #(
  parameter int COORD_W      = 8,
  parameter int SAD_W        = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [COORD_W-1:0] frame_rows,
  input  logic [COORD_W-1:0] frame_cols,
  input  logic [COORD_W-1:0] win_rows,
  input  logic [COORD_W-1:0] win_cols,
  input  logic               issue_stall,
  output logic               issue_valid,
  output logic [COORD_W-1:0] issue_x,
  output logic [COORD_W-1:0] issue_y,
  input  logic               res_valid,
  input  logic [SAD_W-1:0]   res_sad,
  input  logic [COORD_W-1:0] res_x,
  input  logic [COORD_W-1:0] res_y,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SAD_W-1:0]   best_sad,
  output logic [COORD_W-1:0] outx,
  output logic [COORD_W-1:0] outy
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   inflight, inflight_nxt;
  logic [COORD_W-1:0] x_max, y_max;
  logic               bad_dims, res_take, better, zero_hit, last_pos;

  always_comb begin
    bad_dims = (win_rows > frame_rows) || (win_cols > frame_cols) ||
               (win_rows == '0) || (win_cols == '0);
    // results with nothing outstanding (e.g. after a reset) are stale
    res_take = res_valid && (inflight != '0) && ((state == ISSUE) || (state == DRAIN));
    better   = res_take && (res_sad < best_sad);
`ifdef SAD_EARLY_EXIT_EN
    zero_hit = res_take && (res_sad == '0);
`else
    zero_hit = 1'b0;
`endif
    issue_valid = (state == ISSUE) && !issue_stall &&
                  (inflight < CNT_W'(MAX_INFLIGHT)) && !zero_hit;
    last_pos = (issue_x == x_max) && (issue_y == y_max);

    inflight_nxt = inflight;
    if (issue_valid && !res_take)
      inflight_nxt = inflight + CNT_W'(1);
    else if (!issue_valid && res_take)
      inflight_nxt = inflight - CNT_W'(1);

    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = bad_dims ? DONE : ISSUE;
      ISSUE: begin
        if (zero_hit)
          state_nxt = (inflight_nxt == '0) ? DONE : DRAIN;
        else if (issue_valid && last_pos)
          state_nxt = DRAIN;
      end
      DRAIN: if (inflight_nxt == '0) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      inflight <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      best_sad <= '1;
      outx     <= '0;
      outy     <= '0;
      issue_x  <= '0;
      issue_y  <= '0;
      x_max    <= '0;
      y_max    <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= inflight_nxt;
      // status outputs trail the state by one cycle so busy drops as done rises
      busy     <= (state == ISSUE) || (state == DRAIN);
      done     <= (state == DONE);

      if ((state == IDLE) && start) begin
        best_sad <= '1;
        outx     <= '0;
        outy     <= '0;
        err      <= bad_dims;
        x_max    <= frame_cols - win_cols;
        y_max    <= frame_rows - win_rows;
        issue_x  <= '0;
        issue_y  <= '0;
      end else if (better) begin
        best_sad <= res_sad;
        outx     <= res_x;
        outy     <= res_y;
      end

      if (issue_valid && !last_pos) begin
        if (issue_x == x_max) begin
          issue_x <= '0;
          issue_y <= issue_y + COORD_W'(1);
        end else begin
          issue_x <= issue_x + COORD_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sad_search_sequencer.sv
// tb/tb_sad_search_sequencer.sv - table-driven bench with a delayed-return EX pipeline model.
module tb_sad_search_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, issue_stall, res_valid;
  logic [7:0]  frame_rows, frame_cols, win_rows, win_cols;
  logic [7:0]  issue_x, issue_y, res_x, res_y, outx, outy;
  logic [31:0] res_sad, best_sad;
  logic        issue_valid, busy, done, err;

  always #5 clk = ~clk;

  sad_search_sequencer dut (
    .Clk(clk), .Reset(rst), .start(start),
    .frame_rows(frame_rows), .frame_cols(frame_cols),
    .win_rows(win_rows), .win_cols(win_cols),
    .issue_stall(issue_stall), .issue_valid(issue_valid),
    .issue_x(issue_x), .issue_y(issue_y),
    .res_valid(res_valid), .res_sad(res_sad), .res_x(res_x), .res_y(res_y),
    .busy(busy), .done(done), .err(err),
    .best_sad(best_sad), .outx(outx), .outy(outy)
  );

  typedef struct {int due; int sad; int x; int y;} res_t;
  typedef struct {
    int fr, fc, wr, wc, md, lat, sa, sl;
    int e_issue; longint e_best; int e_x, e_y, e_err, e_done;
  } vec_t;

  res_t q[$];
  int tests = 0, fails = 0;
  int cyc, mi, ex, ey, xm, ym, mode, lat, stall_at, stall_len, stall_left;
  int n_issue, order_viol, stall_viol, cap_viol, done_cnt, done_cyc, fall_cyc;
  logic busy_prev, rst_req;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sad_of(input int x, input int y);
    case (mode)
      0: return (x == 2 && y == 1) ? 3 : 10 * (y * 3 + x) + 5;
      1: return 7;
      2: return (x == 1 && y == 0) ? 0 : 100 + x + 4 * y;
      3: return 200 - 10 * x - 3 * y;
      default: return 0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    start = 1'b0;
    rst = rst_req;
    issue_stall = (stall_left > 0);
    if (stall_left > 0) stall_left--;
    if (q.size() > 0 && q[0].due <= cyc) begin
      res_valid = 1'b1;
      res_sad = 32'(q[0].sad);
      res_x = 8'(q[0].x);
      res_y = 8'(q[0].y);
      void'(q.pop_front());
    end else begin
      res_valid = 1'b0;
    end
    @(negedge clk);
    begin
      int took, iss;
      took = (res_valid && mi > 0) ? 1 : 0;
      iss = issue_valid ? 1 : 0;
      if (issue_valid) begin
        n_issue++;
        if (issue_stall) stall_viol++;
        if (mi >= 4) cap_viol++;
        if (int'(issue_x) != ex || int'(issue_y) != ey) order_viol++;
        q.push_back('{cyc + lat, sad_of(int'(issue_x), int'(issue_y)), int'(issue_x), int'(issue_y)});
        if (ex == xm) begin ex = 0; ey++; end else ex++;
        if (n_issue == stall_at) stall_left = stall_len;
      end
      mi = mi + iss - took;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy_prev && !busy) fall_cyc = cyc;
    busy_prev = busy;
  endtask

  task automatic begin_search(input int fr, fc, wr, wc, md, lt, sa, sl);
    mode = md; lat = lt; stall_at = sa; stall_len = sl; stall_left = 0;
    xm = fc - wc; ym = fr - wr; ex = 0; ey = 0;
    n_issue = 0; order_viol = 0; stall_viol = 0; cap_viol = 0;
    done_cnt = 0; done_cyc = -1; fall_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; res_valid = 1'b0; issue_stall = 1'b0;
    frame_rows = 8'(fr); frame_cols = 8'(fc); win_rows = 8'(wr); win_cols = 8'(wc);
    cyc = 0;
    @(negedge clk);
    busy_prev = busy;
  endtask

  task automatic run_to_done(input string name);
    for (int i = 0; i < 500 && done_cnt == 0; i++) step();
    if (done_cnt == 0) chk({name, " timeout"}, 0, 1);
    step(); step();
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1,1,1,1, 1,4,0,0,   1, 7,          0,0,0, 7};
    vecs[1] = '{4,4,2,2, 0,4,0,0,   9, 3,          2,1,0, -1};
    vecs[2] = '{4,4,2,2, 1,4,0,0,   9, 7,          0,0,0, -1};
    vecs[3] = '{4,4,1,5, 0,4,0,0,   0, 32'hFFFFFFFF, 0,0,1, 2};
    vecs[4] = '{4,4,0,2, 0,4,0,0,   0, 32'hFFFFFFFF, 0,0,1, 2};
    vecs[5] = '{2,4,3,1, 0,4,0,0,   0, 32'hFFFFFFFF, 0,0,1, 2};
    vecs[6] = '{4,4,1,1, 3,8,2,3,  16, 161,        3,3,0, -1};
    vecs[7] = '{3,5,3,5, 0,4,0,0,   1, 5,          0,0,0, -1};
    vecs[8] = '{2,5,1,2, 3,4,0,0,   8, 167,        3,1,0, -1};
`ifdef SAD_EARLY_EXIT_EN
    vecs[9] = '{4,4,1,1, 2,4,0,0,   4, 0,          1,0,0, 10};
`else
    vecs[9] = '{4,4,1,1, 2,4,0,0,  16, 0,          1,0,0, -1};
`endif

    rst = 1'b1; rst_req = 1'b0; start = 1'b0; issue_stall = 1'b0; res_valid = 1'b0;
    res_sad = '0; res_x = '0; res_y = '0;
    frame_rows = '0; frame_cols = '0; win_rows = '0; win_cols = '0;
    mi = 0; cyc = 0; mode = 0; lat = 4; stall_left = 0; stall_at = 0; stall_len = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst issue_valid", issue_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst best_sad", best_sad, 32'hFFFFFFFF);
    chk("rst outx", outx, 0);
    chk("rst outy", outy, 0);
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      begin_search(vecs[v].fr, vecs[v].fc, vecs[v].wr, vecs[v].wc,
                   vecs[v].md, vecs[v].lat, vecs[v].sa, vecs[v].sl);
      run_to_done(nm);
      chk({nm, " issues"}, n_issue, vecs[v].e_issue);
      chk({nm, " best_sad"}, best_sad, vecs[v].e_best);
      chk({nm, " outx"}, outx, vecs[v].e_x);
      chk({nm, " outy"}, outy, vecs[v].e_y);
      chk({nm, " err"}, err, vecs[v].e_err);
      chk({nm, " done pulses"}, done_cnt, 1);
      chk({nm, " raster order"}, order_viol, 0);
      chk({nm, " issue while stalled"}, stall_viol, 0);
      chk({nm, " issue at full inflight"}, cap_viol, 0);
      if (vecs[v].e_done >= 0) chk({nm, " done cycle"}, done_cyc, vecs[v].e_done);
      if (vecs[v].e_issue > 0) chk({nm, " busy fall vs done"}, fall_cyc, done_cyc);
    end

    // reset mid-ISSUE with results still in flight; they must be ignored afterward
    begin_search(4, 4, 1, 1, 4, 4, 0, 0);
    for (int i = 0; i < 50 && n_issue < 3; i++) step();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    mi = 0;
    begin
      int n_before;
      n_before = n_issue;
      repeat (8) step();
      chk("rst mid busy", busy, 0);
      chk("rst mid best_sad", best_sad, 32'hFFFFFFFF);
      chk("rst mid outx", outx, 0);
      chk("rst mid no issue", n_issue, n_before);
      chk("rst mid no done", done_cnt, 0);
    end
    q.delete();
    mi = 0;
    begin_search(4, 4, 2, 2, 0, 4, 0, 0);
    run_to_done("post-reset");
    chk("post-reset issues", n_issue, 9);
    chk("post-reset best_sad", best_sad, 3);
    chk("post-reset outx", outx, 2);
    chk("post-reset outy", outy, 1);
    chk("post-reset done pulses", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
